// File: rtl/cla_pipe_adder_pkg.sv
// cla_pipe_adder_pkg: shared defaults and types for the pipelined CLA adder.
// Holds default widths, the group count helper and the sign-bit bundle.
package cla_pipe_adder_pkg;

   localparam int NBIT_DEF  = 16;
   localparam int GBITS_DEF = 4;
   localparam int NSTAGE    = 3;

   // Operand sign bits carried down the pipe for the overflow flag
   typedef struct packed {
      logic am;
      logic bm;
   } sgn_t;

   function automatic int ngrp(input int nbit, input int gbits);
      return nbit / gbits;
   endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand/result streaming bundle with valid/ready.
// master = producer+consumer side, slave = adder side.
interface cla_pipe_adder_if
   import cla_pipe_adder_pkg::*;
#(
   parameter int NBIT = NBIT_DEF
);

   logic            in_valid;
   logic            in_ready;
   logic [NBIT-1:0] a;
   logic [NBIT-1:0] b;
   logic            c_in;
   logic            op;
   logic            out_valid;
   logic            out_ready;
   logic [NBIT-1:0] sum;
   logic            c_out;
   logic            ovf;

   modport master (
      output in_valid, a, b, c_in, op, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, op, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );

endinterface

// File: rtl/cla_group_lookahead.sv
// cla_group_lookahead: combinational group generate/propagate.
// Ports: p, g (GBITS-wide per-bit terms) -> gg (group G), gp (group P).
module cla_group_lookahead #(
   parameter int GBITS = 4
) (
   input  logic [GBITS-1:0] p,
   input  logic [GBITS-1:0] g,
   output logic             gg,
   output logic             gp
);

   always_comb begin : c_grp
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GBITS; i++) begin
         gg = g[i] | (p[i] & gg);
         gp = gp & p[i];
      end
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: 3-stage pipelined carry-lookahead add/subtract.
// Ports: clk, rst (sync, active-high), bus (slave: a, b, c_in, op, sum, c_out, ovf, valid/ready).
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int NBIT  = NBIT_DEF,
   parameter int GBITS = GBITS_DEF
) (
   input  logic           clk,
   input  logic           rst,
   cla_pipe_adder_if.slave bus
);

   localparam int NGRP = ngrp(NBIT, GBITS);

   if (NBIT < 2 || GBITS < 1 || (NBIT % GBITS) != 0) begin : g_chk
      $error("cla_pipe_adder: GBITS must divide NBIT and NBIT >= 2");
   end

   logic            en;
   logic [NBIT-1:0] bx;
   logic            cx;

   // S1
   logic            v1;
   logic [NBIT-1:0] p1;
   logic [NBIT-1:0] g1;
   logic            cx1;
   sgn_t            s1;

   // S2
   logic [NGRP-1:0] gg;
   logic [NGRP-1:0] gp;
   logic [NGRP-1:0] gc;
   logic            v2;
   logic [NBIT-1:0] p2;
   logic [NBIT-1:0] g2;
   logic [NGRP-1:0] gc2;
   sgn_t            s2;

   // S3
   logic [NBIT-1:0] s3;
   logic            co3;
   logic            ov3;
   logic            v3;
   logic [NBIT-1:0] sum_q;
   logic            co_q;
   logic            ov_q;

   // Whole pipe moves together; bubbles stay in place
   assign en           = !v3 || bus.out_ready;
   assign bus.in_ready = en;

   assign bx = bus.op ? ~bus.b : bus.b;
   assign cx = bus.op | bus.c_in;

   for (genvar k = 0; k < NGRP; k++) begin : g_la
      cla_group_lookahead #(.GBITS(GBITS)) u_la (
         .p  (p1[k*GBITS +: GBITS]),
         .g  (g1[k*GBITS +: GBITS]),
         .gg (gg[k]),
         .gp (gp[k])
      );
   end

   // Group carry-ins rippled across groups from the pipe carry-in
   always_comb begin : c_gc
      logic c;
      c  = cx1;
      gc = '0;
      for (int i = 0; i < NGRP; i++) begin
         gc[i] = c;
         c     = gg[i] | (gp[i] & c);
      end
   end

   // Intra-group ripple restarted at each group boundary
   always_comb begin : c_sum
      logic cr;
      cr  = 1'b0;
      s3  = '0;
      for (int i = 0; i < NBIT; i++) begin
         if ((i % GBITS) == 0) cr = gc2[i / GBITS];
         s3[i] = p2[i] ^ cr;
         cr    = g2[i] | (p2[i] & cr);
      end
      co3 = cr;
      ov3 = (s2.am == s2.bm) && (s3[NBIT-1] != s2.am);
   end

   always_ff @(posedge clk) begin : r_s1
      if (rst) begin
         v1  <= 1'b0;
         p1  <= '0;
         g1  <= '0;
         cx1 <= 1'b0;
         s1  <= '0;
      end else if (en) begin
         v1  <= bus.in_valid;
         p1  <= bus.a ^ bx;
         g1  <= bus.a & bx;
         cx1 <= cx;
         s1  <= '{am: bus.a[NBIT-1], bm: bx[NBIT-1]};
      end
   end

   always_ff @(posedge clk) begin : r_s2
      if (rst) begin
         v2  <= 1'b0;
         p2  <= '0;
         g2  <= '0;
         gc2 <= '0;
         s2  <= '0;
      end else if (en) begin
         v2  <= v1;
         p2  <= p1;
         g2  <= g1;
         gc2 <= gc;
         s2  <= s1;
      end
   end

   always_ff @(posedge clk) begin : r_s3
      if (rst) begin
         v3    <= 1'b0;
         sum_q <= '0;
         co_q  <= 1'b0;
         ov_q  <= 1'b0;
      end else if (en) begin
         v3    <= v2;
         sum_q <= s3;
         co_q  <= co3;
         ov_q  <= ov3;
      end
   end

   assign bus.out_valid = v3;
   assign bus.sum       = sum_q;
   assign bus.c_out     = co_q;
   assign bus.ovf       = ov_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for the pipelined CLA adder.
// Main NBIT=4/GBITS=2 instance plus a width/group sweep of nine instances.
module tb_cla_pipe_adder;
   import cla_pipe_adder_pkg::*;

   typedef struct {
      longint s;
      bit     co;
      bit     ov;
      int     acc;
      bit     lat;
   } exp_t;

   logic clk;
   logic rst;
   logic rst_s;
   int   cyc;
   int   nchk;
   int   npass;
   int   sw_done;
   bit   bp;
   bit   rdy_fix;
   bit   lat_mode;
   exp_t q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      nchk++;
      if (act == req) npass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
   endtask

   // Plain integer reference: unsigned sum for result/carry, signed range for overflow
   function automatic exp_t model(input int nb, input longint a, input longint b,
                                  input bit cin, input bit op);
      exp_t   e;
      longint m, sa, sb, ss, full;
      m  = longint'(1) << nb;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      if (op) begin
         full = a - b + m;
         e.co = (a >= b);
         ss   = sa - sb;
      end else begin
         full = a + b + longint'(cin);
         e.co = (full >= m);
         ss   = sa + sb + longint'(cin);
      end
      e.s   = full % m;
      e.ov  = (ss < -(m / 2)) || (ss >= m / 2);
      e.acc = 0;
      e.lat = 0;
      return e;
   endfunction

   // ---------------- main instance ----------------
   cla_pipe_adder_if #(.NBIT(4)) mif ();

   cla_pipe_adder #(.NBIT(4), .GBITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif.slave)
   );

   always @(negedge clk) mif.out_ready = bp ? 1'($urandom % 2) : rdy_fix;

   task automatic drive(input logic [3:0] a_, input logic [3:0] b_,
                        input bit ci, input bit op_, input exp_t e);
      bit ok;
      mif.a        = a_;
      mif.b        = b_;
      mif.c_in     = ci;
      mif.op       = op_;
      mif.in_valid = 1'b1;
      ok = 0;
      for (int w = 0; w < 200 && !ok; w++) begin
         #1;
         if (mif.in_ready) begin
            e.acc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
            ok = 1;
         end
         @(negedge clk);
      end
      mif.in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic send(input logic [3:0] a_, input logic [3:0] b_,
                       input bit ci, input bit op_);
      drive(a_, b_, ci, op_, model(4, longint'(a_), longint'(b_), ci, op_));
   endtask

   task automatic sendx(input logic [3:0] a_, input logic [3:0] b_,
                        input bit ci, input bit op_,
                        input longint s, input bit co, input bit ov);
      exp_t e;
      e.s  = s;
      e.co = co;
      e.ov = ov;
      e.acc = 0;
      e.lat = 0;
      drive(a_, b_, ci, op_, e);
   endtask

   task automatic drain(input string nm);
      for (int w = 0; w < 300 && q.size() > 0; w++) @(negedge clk);
      chk(nm, q.size(), 0);
   endtask

   bit          prev_stall;
   logic [3:0]  ps;
   logic        pco;
   logic        pov;

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst) begin
         prev_stall = 0;
      end else begin
         chk("in_ready", mif.in_ready, !mif.out_valid || mif.out_ready);
         if (prev_stall) begin
            chk("hold_valid", mif.out_valid, 1);
            chk("hold_sum", mif.sum, ps);
            chk("hold_cout", mif.c_out, pco);
            chk("hold_ovf", mif.ovf, pov);
         end
         if (mif.out_valid && mif.out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               chk("sum", longint'(mif.sum), e.s);
               chk("c_out", mif.c_out, e.co);
               chk("ovf", mif.ovf, e.ov);
               if (e.lat) chk("latency", cyc - e.acc, NSTAGE);
            end
         end
         prev_stall = mif.out_valid && !mif.out_ready;
         ps  = mif.sum;
         pco = mif.c_out;
         pov = mif.ovf;
      end
   end

   // ---------------- parameter sweep ----------------
   for (genvar gi = 0; gi < 9; gi++) begin : g_sw
      localparam int NB = (gi < 3) ? 4 : ((gi < 6) ? 16 : 32);
      localparam int GB = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 4 : NB);

      cla_pipe_adder_if #(.NBIT(NB)) sif ();

      cla_pipe_adder #(.NBIT(NB), .GBITS(GB)) u_dut (
         .clk (clk),
         .rst (rst_s),
         .bus (sif.slave)
      );

      exp_t sq[$];

      initial begin
         sif.in_valid  = 1'b0;
         sif.out_ready = 1'b1;
         sif.a         = '0;
         sif.b         = '0;
         sif.c_in      = 1'b0;
         sif.op        = 1'b0;
         @(negedge clk);
         while (rst_s) @(negedge clk);
         for (int n = 0; n < 1000; n++) begin
            sif.a        = NB'($urandom);
            sif.b        = NB'($urandom);
            sif.c_in     = 1'($urandom);
            sif.op       = 1'($urandom);
            sif.in_valid = 1'b1;
            #1;
            if (sif.in_ready)
               sq.push_back(model(NB, longint'(sif.a), longint'(sif.b), sif.c_in, sif.op));
            else
               chk($sformatf("sw%0d_ready", gi), 0, 1);
            @(negedge clk);
         end
         sif.in_valid = 1'b0;
         for (int w = 0; w < 100 && sq.size() > 0; w++) @(negedge clk);
         chk($sformatf("sw%0d_drain", gi), sq.size(), 0);
         sw_done++;
      end

      always @(negedge clk) begin
         exp_t e;
         #2;
         if (!rst_s && sif.out_valid) begin
            if (sq.size() == 0) begin
               chk($sformatf("sw%0d_spurious", gi), 1, 0);
            end else begin
               e = sq.pop_front();
               chk($sformatf("sw%0d_n%0d_g%0d_sum", gi, NB, GB), longint'(sif.sum), e.s);
               chk($sformatf("sw%0d_cout", gi), sif.c_out, e.co);
               chk($sformatf("sw%0d_ovf", gi), sif.ovf, e.ov);
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      nchk     = 0;
      npass    = 0;
      sw_done  = 0;
      rst      = 1'b1;
      rst_s    = 1'b1;
      bp       = 0;
      rdy_fix  = 1;
      lat_mode = 1;
      mif.in_valid = 1'b0;
      mif.a        = '0;
      mif.b        = '0;
      mif.c_in     = 1'b0;
      mif.op       = 1'b0;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      rst_s = 1'b0;
      #1;
      chk("rst_out_valid", mif.out_valid, 0);
      chk("rst_sum", mif.sum, 0);
      chk("rst_c_out", mif.c_out, 0);
      chk("rst_ovf", mif.ovf, 0);
      chk("rst_in_ready", mif.in_ready, 1);
      @(negedge clk);

      // directed edges, add with c_in=0, signed edges, subtract
      sendx(4'd5, 4'd10, 0, 0, 15, 0, 0);
      sendx(4'd6, 4'd10, 0, 0, 0, 1, 0);
      sendx(4'd7, 4'd1, 0, 0, 8, 0, 1);
      sendx(4'd2, 4'd3, 0, 1, 15, 0, 0);
      sendx(4'd8, 4'd1, 0, 1, 7, 1, 1);
      sendx(4'd15, 4'd0, 1, 0, 0, 1, 0);
      sendx(4'd2, 4'd3, 1, 1, 15, 0, 0);

      // back-to-back streaming
      for (int i = 0; i < 20; i++)
         send(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      drain("stream_drain");

      // random backpressure with input gaps
      lat_mode = 0;
      bp = 1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom % 4 == 0) @(negedge clk);
         send(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      end
      bp = 0;
      drain("bp_drain");

      // reset with a full, stalled pipe
      rdy_fix = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         send(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk("full_out_valid", mif.out_valid, 1);
      chk("full_in_ready", mif.in_ready, 0);
      @(negedge clk);
      rst     = 1'b1;
      rdy_fix = 1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", mif.out_valid, 0);
      chk("mid_rst_sum", mif.sum, 0);
      chk("mid_rst_c_out", mif.c_out, 0);
      chk("mid_rst_ovf", mif.ovf, 0);
      chk("mid_rst_in_ready", mif.in_ready, 1);
      @(negedge clk);
      lat_mode = 1;
      send(4'd9, 4'd9, 0, 0);
      drain("post_rst_drain");

      for (int w = 0; w < 5000 && sw_done < 9; w++) @(negedge clk);
      chk("sweep_done", sw_done, 9);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
